audio_clk_gen_tdm: RTL



---
 rtl/audio_clk_gen_tdm.sv | 130 +++++++++++++
 1 files changed

// File: rtl/audio_clk_gen_tdm.sv
// Audio clock generator: MCLK, BCLK and LRCK/frame sync from the system clock, plus
// single-cycle LOAD/OUT_SHIFT/IN_SHIFT strobes and slot/bit indices for the serdes.
module audio_clk_gen_tdm #(
    parameter int unsigned MCLK_DIV  = 8,
    parameter int unsigned BCLK_DIV  = 8,
    parameter int unsigned SLOT_BITS = 24,
    parameter int unsigned SLOTS     = 2,
    parameter int unsigned FORMAT    = 0
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       EN,
    output logic       MCLK,
    output logic       BCLK,
    output logic       LRCK,
    output logic       LOAD,
    output logic       OUT_SHIFT,
    output logic       IN_SHIFT,
    output logic [3:0] SLOT,
    output logic [4:0] BITIDX
);

    localparam int unsigned BP = MCLK_DIV * BCLK_DIV;
    localparam int unsigned FB = SLOTS * SLOT_BITS;
    localparam int unsigned CW = (BP > 1) ? $clog2(BP) : 1;
    localparam int unsigned MW = (MCLK_DIV > 1) ? $clog2(MCLK_DIV) : 1;

    localparam logic [CW-1:0] CycLast  = CW'(BP - 1);
    localparam logic [CW-1:0] CycHalf  = CW'(BP / 2);
    localparam logic [MW-1:0] MLast    = MW'(MCLK_DIV - 1);
    localparam logic [MW-1:0] MHalf    = MW'(MCLK_DIV / 2);
    localparam logic [4:0]    BitLast  = 5'(SLOT_BITS - 1);
    localparam logic [3:0]    SlotLast = 4'(SLOTS - 1);
    localparam logic [9:0]    FLast    = 10'(FB - 1);
    localparam logic [9:0]    FHalf    = 10'(FB / 2);

    if (MCLK_DIV < 2 || (MCLK_DIV % 2) != 0) begin : g_bad_mclk_div
        $error("audio_clk_gen_tdm: MCLK_DIV must be even and >= 2");
    end
    if (BCLK_DIV < 1) begin : g_bad_bclk_div
        $error("audio_clk_gen_tdm: BCLK_DIV must be >= 1");
    end
    if (SLOT_BITS < 2 || SLOT_BITS > 32) begin : g_bad_slot_bits
        $error("audio_clk_gen_tdm: SLOT_BITS must be 2..32");
    end
    if (SLOTS < 1 || SLOTS > 16) begin : g_bad_slots
        $error("audio_clk_gen_tdm: SLOTS must be 1..16");
    end
    if (FORMAT > 2) begin : g_bad_format
        $error("audio_clk_gen_tdm: FORMAT must be 0, 1 or 2");
    end
    if (FORMAT < 2 && (SLOTS % 2) != 0) begin : g_bad_stereo
        $error("audio_clk_gen_tdm: I2S and left-justified need an even SLOTS");
    end

    logic          run;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [MW-1:0] mcnt_q, mcnt_d;
    logic [4:0]    bit_q, bit_d;
    logic [3:0]    slot_q, slot_d;
    logic [9:0]    fpos, fpos_next;
    logic          mclk_d, bclk_d, lrck_d, load_d, out_shift_d, in_shift_d;

    // mcnt tracks cyc mod MCLK_DIV; BP is a multiple of MCLK_DIV so they wrap together
    always_comb begin
        run    = !RESET && EN;
        cyc_d  = '0;
        mcnt_d = '0;
        bit_d  = '0;
        slot_d = '0;
        if (run) begin
            mcnt_d = (mcnt_q == MLast) ? '0 : mcnt_q + 1'b1;
            cyc_d  = (cyc_q == CycLast) ? '0 : cyc_q + 1'b1;
            bit_d  = bit_q;
            slot_d = slot_q;
            if (cyc_q == CycLast) begin
                bit_d = (bit_q == BitLast) ? '0 : bit_q + 1'b1;
                if (bit_q == BitLast) begin
                    slot_d = (slot_q == SlotLast) ? '0 : slot_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        fpos      = {6'd0, slot_q} * 10'(SLOT_BITS) + {5'd0, bit_q};
        fpos_next = (fpos == FLast) ? '0 : fpos + 10'd1;
        case (FORMAT)
            0:       lrck_d = (fpos_next >= FHalf);
            1:       lrck_d = (fpos < FHalf);
            default: lrck_d = (fpos == FLast);
        endcase
        mclk_d      = (mcnt_q >= MHalf);
        bclk_d      = (cyc_q >= CycHalf);
        out_shift_d = (cyc_q == '0);
        in_shift_d  = (cyc_q == CycHalf);
        load_d      = (cyc_q == '0) && (bit_q == '0) && (slot_q == '0);
    end

    always_ff @(posedge CLK) begin
        if (RESET || !EN) begin
            cyc_q     <= '0;
            mcnt_q    <= '0;
            bit_q     <= '0;
            slot_q    <= '0;
            MCLK      <= 1'b0;
            BCLK      <= 1'b0;
            LRCK      <= 1'b0;
            LOAD      <= 1'b0;
            OUT_SHIFT <= 1'b0;
            IN_SHIFT  <= 1'b0;
            SLOT      <= '0;
            BITIDX    <= '0;
        end else begin
            cyc_q     <= cyc_d;
            mcnt_q    <= mcnt_d;
            bit_q     <= bit_d;
            slot_q    <= slot_d;
            MCLK      <= mclk_d;
            BCLK      <= bclk_d;
            LRCK      <= lrck_d;
            LOAD      <= load_d;
            OUT_SHIFT <= out_shift_d;
            IN_SHIFT  <= in_shift_d;
            SLOT      <= slot_q;
            BITIDX    <= bit_q;
        end
    end

endmodule
